// File: rtl/mca_histogram_pkg.sv
// mca_histogram_pkg
//   Shared definitions for the multichannel-analyser histogram engine:
//   default widths, top-level state encoding and read-modify-write phase
//   encoding.
package mca_histogram_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_CNT_W  = 32;
  localparam int DEF_LOST_W = 16;
  localparam int ACC_W      = 32;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // PH_RD doubles as the engine-idle phase: a new event may be accepted
  // (its address issued) only while the engine sits here.
  typedef enum logic [1:0] {
    PH_RD   = 2'd0,
    PH_WAIT = 2'd1,
    PH_WR   = 2'd2
  } phase_t;

endpackage

// File: rtl/mca_histogram_bin_ram.sv
// mca_bin_ram
//   Simple dual-port bin memory, one-cycle registered reads, no reset.
//   Ports:
//     clk      - clock
//     addr_a   - port A address (RMW / clear sweep)
//     we_a     - port A write enable
//     wdata_a  - port A write data
//     rdata_a  - port A registered read data
//     addr_b   - port B address (host read)
//     rdata_b  - port B registered read data
module mca_bin_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              we_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= wdata_a;
    end
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/mca_histogram.sv
// mca_histogram
//   Multichannel-analyser histogram engine. Bins event strobes into a
//   2^ADDR_W x CNT_W counter memory with a 3-phase read-modify-write and
//   serves a registered host read port.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ST_CLEAR | sweeping zeros into every bin, commands/events ignored
//   ST_IDLE  | bins held, events ignored, waiting for start/clear
//   ST_RUN   | acquiring: events binned, busy-engine events counted lost
//
//   Ports:
//     CLOCK_50        - sole clock
//     rst             - synchronous active-high reset
//     cmd_start       - pulse: begin/resume acquisition
//     cmd_pause       - pulse: stop acquisition, keep bins
//     cmd_clear       - pulse: zero bins and counters
//     event_strobe    - single-cycle event marker
//     event_channel   - bin index for the event
//     channel_address - host read index
//     channel_count   - bin value at channel_address (2-cycle latency)
//     running         - state is ST_RUN
//     busy            - state is ST_CLEAR
//     accepted_count  - events binned since last clear (wrapping)
//     lost_count      - events dropped in RUN while engine busy (saturating)
module mca_histogram
  import mca_histogram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LOST_W = DEF_LOST_W
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_pause,
  input  logic              cmd_clear,
  input  logic              event_strobe,
  input  logic [ADDR_W-1:0] event_channel,
  input  logic [ADDR_W-1:0] channel_address,
  output logic [CNT_W-1:0]  channel_count,
  output logic              running,
  output logic              busy,
  output logic [ACC_W-1:0]  accepted_count,
  output logic [LOST_W-1:0] lost_count
);

  state_t            state;
  phase_t            phase;
  logic [ADDR_W-1:0] sweep_addr;
  logic [ADDR_W-1:0] rmw_addr;
  logic [CNT_W-1:0]  rd_data_q;

  logic [ADDR_W-1:0] ram_addr_a;
  logic              ram_we_a;
  logic [CNT_W-1:0]  ram_wdata_a;
  logic [CNT_W-1:0]  ram_rdata_a;
  logic [CNT_W-1:0]  ram_rdata_b;

  logic accept;
  logic lost_ev;

  // An event coinciding with a clear pulse is dropped silently: the clear
  // zeroes the counters in that same cycle, so neither count would survive.
  assign accept  = event_strobe && (state == ST_RUN) && (phase == PH_RD) && !cmd_clear;
  assign lost_ev = event_strobe && (state == ST_RUN) && (phase != PH_RD) && !cmd_clear;

  // Port A is shared: the in-flight WR always wins; the clear sweep only
  // writes while the engine is idle, which defers the sweep behind any WR.
  always_comb begin
    ram_addr_a  = rmw_addr;
    ram_we_a    = 1'b0;
    ram_wdata_a = '0;
    if (phase == PH_WR) begin
      ram_we_a    = 1'b1;
      ram_wdata_a = (&rd_data_q) ? rd_data_q : rd_data_q + CNT_W'(1);
    end else if (phase == PH_RD && state == ST_CLEAR) begin
      ram_addr_a = sweep_addr;
      ram_we_a   = 1'b1;
    end else if (phase == PH_RD) begin
      ram_addr_a = event_channel;
    end
  end

  mca_bin_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (CNT_W)
  ) u_ram (
    .clk     (CLOCK_50),
    .addr_a  (ram_addr_a),
    .we_a    (ram_we_a),
    .wdata_a (ram_wdata_a),
    .rdata_a (ram_rdata_a),
    .addr_b  (channel_address),
    .rdata_b (ram_rdata_b)
  );

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state          <= ST_CLEAR;
      phase          <= PH_RD;
      sweep_addr     <= '0;
      rmw_addr       <= '0;
      rd_data_q      <= '0;
      accepted_count <= '0;
      lost_count     <= '0;
      running        <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (phase)
        PH_RD: begin
          if (accept) begin
            phase    <= PH_WAIT;
            rmw_addr <= event_channel;
          end
        end
        PH_WAIT: begin
          rd_data_q <= ram_rdata_a;
          phase     <= PH_WR;
        end
        PH_WR:   phase <= PH_RD;
        default: phase <= PH_RD;
      endcase

      if (accept) begin
        accepted_count <= accepted_count + ACC_W'(1);
      end
      if (lost_ev && !(&lost_count)) begin
        lost_count <= lost_count + LOST_W'(1);
      end

      // Entering CLEAR below overrides the counter updates above.
      case (state)
        ST_CLEAR: begin
          if (phase == PH_RD) begin
            if (sweep_addr == '1) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              sweep_addr <= sweep_addr + ADDR_W'(1);
            end
          end
        end
        ST_IDLE: begin
          if (cmd_clear) begin
            state          <= ST_CLEAR;
            sweep_addr     <= '0;
            accepted_count <= '0;
            lost_count     <= '0;
            busy           <= 1'b1;
          end else if (cmd_start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cmd_clear) begin
            state          <= ST_CLEAR;
            sweep_addr     <= '0;
            accepted_count <= '0;
            lost_count     <= '0;
            busy           <= 1'b1;
            running        <= 1'b0;
          end else if (cmd_pause) begin
            state   <= ST_IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state      <= ST_CLEAR;
          sweep_addr <= '0;
          busy       <= 1'b1;
          running    <= 1'b0;
        end
      endcase
    end
  end

  // Host read register; forced to zero while the sweep is in progress.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      channel_count <= '0;
    end else if (state == ST_CLEAR) begin
      channel_count <= '0;
    end else begin
      channel_count <= ram_rdata_b;
    end
  end

endmodule
